// File: rtl/sample_sequencer_10hz_pkg.sv
// Shared definitions for the 10 Hz sample sequencer.
//   - seq_state_e : frame FSM state encoding (IDLE/START/WAIT/DONE)
//   - DEF_*       : default values for the top-level parameters
//   - idx_width   : register width needed to index the sensors
//   - cnt_width   : register width of the per-sensor timeout counter
package sample_sequencer_10hz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int DEF_NUM_SENSORS    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 20000;
  localparam int DEF_TIME_W         = 24;

  // A single sensor still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // The counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sample_sequencer_10hz_tick_sync_edge.sv
// tick_sync_edge: three-flop synchronizer with rising-edge detector for a
// slow asynchronous input. Emits a one-clock pulse per rising edge, two
// clocks after the input is first sampled high.
// Ports:
//   clk        in  sampling clock
//   rst_n      in  asynchronous active-low reset
//   async_in   in  slow asynchronous input
//   rise_pulse out one-cycle pulse per rising edge of async_in
module tick_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // s1 is the metastability catcher; the edge is detected between s2 and s3.
  assign rise_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/sample_sequencer_10hz.sv
// sample_sequencer_10hz: turns each rising edge of the 10 Hz divider clock
// into one sensor-sampling frame on the 1 MHz system clock. Each frame bumps
// the mission-time counter, then strobes the sensor readers one at a time,
// waiting for each reader's done before starting the next.
// Build option: define SAMPLE_SEQ_TIMEOUT_EN to add the per-sensor timeout
// counter and sticky TIMEOUT_FLAGS; without it a reader is waited on forever
// and TIMEOUT_FLAGS reads 0.
// Ports:
//   CLK_1MHZ_IN   in  system clock
//   RESET         in  asynchronous active-low reset
//   CLK_10HZ_IN   in  10 Hz divider clock (asynchronous)
//   SENSOR_DONE   in  per-reader completion; only the current reader's bit is used
//   SENSOR_START  out one-hot one-cycle start strobe
//   MISSION_TIME  out 10 Hz tick count since reset (wraps)
//   FRAME_READY   out one-cycle pulse at frame end
//   BUSY          out frame in progress (low in the FRAME_READY cycle)
//   OVERRUN       out sticky: tick arrived while a frame was in progress
//   TIMEOUT_FLAGS out sticky: reader i timed out
module sample_sequencer_10hz
  import sample_sequencer_10hz_pkg::*;
#(
  parameter int NUM_SENSORS    = DEF_NUM_SENSORS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TIME_W         = DEF_TIME_W
) (
  input  logic                   CLK_1MHZ_IN,
  input  logic                   RESET,
  input  logic                   CLK_10HZ_IN,
  input  logic [NUM_SENSORS-1:0] SENSOR_DONE,
  output logic [NUM_SENSORS-1:0] SENSOR_START,
  output logic [TIME_W-1:0]      MISSION_TIME,
  output logic                   FRAME_READY,
  output logic                   BUSY,
  output logic                   OVERRUN,
  output logic [NUM_SENSORS-1:0] TIMEOUT_FLAGS
);

  localparam int IDX_W = idx_width(NUM_SENSORS);

  if (NUM_SENSORS < 1 || NUM_SENSORS > 8) begin : g_bad_num_sensors
    $error("sample_sequencer_10hz: NUM_SENSORS must be 1..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("sample_sequencer_10hz: TIMEOUT_CYCLES must be at least 1");
  end

  logic tick;

  tick_sync_edge u_tick_sync (
    .clk        (CLK_1MHZ_IN),
    .rst_n      (RESET),
    .async_in   (CLK_10HZ_IN),
    .rise_pulse (tick)
  );

  seq_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_SENSORS-1:0] start_q, start_d;
  logic [TIME_W-1:0]      time_q, time_d;
  logic                   frame_ready_q, frame_ready_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic                   done_cur;
  logic                   timed_out;
  logic                   last_idx;

`ifdef SAMPLE_SEQ_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_SENSORS-1:0] tflags_q, tflags_d;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    start_d       = '0;
    frame_ready_d = 1'b0;
    busy_d        = busy_q;
    overrun_d     = overrun_q;
    time_d        = time_q + TIME_W'(tick);
    done_cur      = SENSOR_DONE[idx_q];
    last_idx      = (idx_q == IDX_W'(NUM_SENSORS - 1));
`ifdef SAMPLE_SEQ_TIMEOUT_EN
    cnt_d         = cnt_q;
    tflags_d      = tflags_q;
    timed_out     = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    timed_out     = 1'b0;
`endif

    // Ticks during a frame are flagged and dropped, never queued.
    if (tick && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    // Strobes and FRAME_READY are registered on entry to the state they
    // belong to, so they are high exactly during that state's cycle.
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          idx_d   = '0;
          busy_d  = 1'b1;
          start_d = NUM_SENSORS'(1);
          state_d = ST_START;
        end
      end
      ST_START: begin
`ifdef SAMPLE_SEQ_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_cur || timed_out) begin
`ifdef SAMPLE_SEQ_TIMEOUT_EN
          // A done arriving on the last counted cycle wins over the timeout.
          if (!done_cur) begin
            tflags_d[idx_q] = 1'b1;
          end
`endif
          if (last_idx) begin
            frame_ready_d = 1'b1;
            busy_d        = 1'b0;
            state_d       = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            start_d = NUM_SENSORS'(1) << idx_d;
            state_d = ST_START;
          end
        end else begin
`ifdef SAMPLE_SEQ_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_1MHZ_IN or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      start_q       <= '0;
      time_q        <= '0;
      frame_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef SAMPLE_SEQ_TIMEOUT_EN
      cnt_q         <= '0;
      tflags_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      start_q       <= start_d;
      time_q        <= time_d;
      frame_ready_q <= frame_ready_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
`ifdef SAMPLE_SEQ_TIMEOUT_EN
      cnt_q         <= cnt_d;
      tflags_q      <= tflags_d;
`endif
    end
  end

  assign SENSOR_START = start_q;
  assign MISSION_TIME = time_q;
  assign FRAME_READY  = frame_ready_q;
  assign BUSY         = busy_q;
  assign OVERRUN      = overrun_q;
`ifdef SAMPLE_SEQ_TIMEOUT_EN
  assign TIMEOUT_FLAGS = tflags_q;
`else
  assign TIMEOUT_FLAGS = '0;
`endif

endmodule
